// File: rtl/soc_trace_buffer.sv
// Trace capture unit: records multi-channel samples into a circular buffer,
// stops on trigger / post-trigger window / stop, and dumps oldest-first through a read port.
module soc_trace_buffer #(
   parameter int DW    = 32,
   parameter int CH    = 4,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic               g_clk,
   input  logic               g_reset,
   input  logic               arm,
   input  logic               stop,
   input  logic [1:0]         mode,
   input  logic [AW:0]        post_count,
   input  logic               trig,
   input  logic               smp_valid,
   input  logic [CH*DW-1:0]   smp_data,
   input  logic               rd_en,
   input  logic [AW-1:0]      rd_idx,
   input  logic [CW-1:0]      rd_ch,
   output logic [DW-1:0]      rd_data,
   output logic               rd_valid,
   output logic [1:0]         state,
   output logic [AW:0]        filled,
   output logic [AW-1:0]      trig_pos,
   output logic               done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_TRIG  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
   localparam logic [AW:0] POST_MAX = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] ONE      = (AW+1)'(1);

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]     filled_q, filled_d;
   logic [AW-1:0]   trig_ptr_q, trig_ptr_d;
   logic            trig_seen_q, trig_seen_d;
   logic [1:0]      mode_q, mode_d;
   logic [AW:0]     post_lat_q, post_lat_d;
   logic [AW:0]     post_cnt_q, post_cnt_d;
   logic [DW-1:0]   rd_data_q, rd_data_d;
   logic            rd_valid_q;
   logic            mem_we;

   logic [CH*DW-1:0] mem_q [DEPTH];

   logic [AW-1:0]    oldest;
   logic [AW-1:0]    rd_slot;
   logic [CH*DW-1:0] rd_word;
   logic [CH*DW-1:0] rd_shift;
   logic             rd_hit;

   // Next-state and write control; arm outranks stop/trig, stop outranks the trigger exit.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      filled_d    = filled_q;
      trig_ptr_d  = trig_ptr_q;
      trig_seen_d = trig_seen_q;
      mode_d      = mode_q;
      post_lat_d  = post_lat_q;
      post_cnt_d  = post_cnt_q;
      mem_we      = 1'b0;
      if (arm) begin
         state_d     = S_ARMED;
         wr_ptr_d    = '0;
         filled_d    = '0;
         trig_ptr_d  = '0;
         trig_seen_d = 1'b0;
         post_cnt_d  = '0;
         mode_d      = mode;
         post_lat_d  = (post_count > POST_MAX) ? POST_MAX : post_count;
      end else begin
         case (state_q)
            S_ARMED: begin
               mem_we = smp_valid;
               if (trig && (mode_q != 2'd2)) begin
                  trig_ptr_d  = wr_ptr_q;
                  trig_seen_d = 1'b1;
                  if ((mode_q == 2'd1) && (post_lat_q != '0)) begin
                     state_d    = S_TRIG;
                     post_cnt_d = post_lat_q;
                  end else begin
                     state_d = S_DONE;
                  end
               end
               if (stop) state_d = S_DONE;
            end
            S_TRIG: begin
               mem_we = smp_valid;
               if (smp_valid) begin
                  post_cnt_d = post_cnt_q - ONE;
                  if (post_cnt_q == ONE) state_d = S_DONE;
               end
               if (stop) state_d = S_DONE;
            end
            default: ;
         endcase
         if (mem_we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (filled_q != FULL) filled_d = filled_q + ONE;
         end
      end
   end

   // Once the buffer has wrapped, the slot about to be overwritten is the oldest one.
   always_comb begin
      oldest    = (filled_q == FULL) ? wr_ptr_q : '0;
      rd_slot   = oldest + rd_idx;
      rd_word   = mem_q[rd_slot];
      rd_shift  = rd_word >> (DW * int'(rd_ch));
      rd_hit    = ({1'b0, rd_idx} < filled_q) && (int'(rd_ch) < CH);
      rd_data_d = rd_data_q;
      if (rd_en) rd_data_d = rd_hit ? rd_shift[DW-1:0] : '0;
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         filled_q    <= '0;
         trig_ptr_q  <= '0;
         trig_seen_q <= 1'b0;
         mode_q      <= 2'd0;
         post_lat_q  <= '0;
         post_cnt_q  <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         filled_q    <= filled_d;
         trig_ptr_q  <= trig_ptr_d;
         trig_seen_q <= trig_seen_d;
         mode_q      <= mode_d;
         post_lat_q  <= post_lat_d;
         post_cnt_q  <= post_cnt_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_en;
      end
   end

   // Sample storage is deliberately not reset; a same-cycle read sees the old word.
   always_ff @(posedge g_clk) begin
      if (mem_we) mem_q[wr_ptr_q] <= smp_data;
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign state    = state_q;
   assign filled   = filled_q;
   assign trig_pos = trig_seen_q ? (trig_ptr_q - oldest) : '0;
   assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_soc_trace_buffer.sv
// Bench for soc_trace_buffer: directed scenarios plus randomized runs, reads scored
// against a queue-based history model of everything captured in the current run.
module tb_soc_trace_buffer;

   localparam int DW    = 32;
   localparam int CH    = 4;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int CW    = 2;

   logic               g_clk;
   logic               g_reset;
   logic               arm, stop, trig, smp_valid, rd_en;
   logic [1:0]         mode;
   logic [AW:0]        post_count;
   logic [CH*DW-1:0]   smp_data;
   logic [AW-1:0]      rd_idx;
   logic [CW-1:0]      rd_ch;
   logic [DW-1:0]      rd_data;
   logic               rd_valid;
   logic [1:0]         state;
   logic [AW:0]        filled;
   logic [AW-1:0]      trig_pos;
   logic               done;

   soc_trace_buffer #(.DW(DW), .CH(CH), .DEPTH(DEPTH)) dut (
      .g_clk(g_clk), .g_reset(g_reset), .arm(arm), .stop(stop), .mode(mode),
      .post_count(post_count), .trig(trig), .smp_valid(smp_valid), .smp_data(smp_data),
      .rd_en(rd_en), .rd_idx(rd_idx), .rd_ch(rd_ch), .rd_data(rd_data), .rd_valid(rd_valid),
      .state(state), .filled(filled), .trig_pos(trig_pos), .done(done)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   int n_vec = 0;
   int n_err = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] last_rd = '0;

   // Reference model: the run is the list of every sample accepted since arm.
   int m_st, m_mode, m_post, m_rem, m_trig;
   logic [CH*DW-1:0] hist[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_filled();
      return (hist.size() > DEPTH) ? DEPTH : hist.size();
   endfunction

   function automatic int m_trigpos();
      int rel;
      if (m_trig < 0) return 0;
      rel = m_trig - (hist.size() - m_filled());
      return ((rel % DEPTH) + DEPTH) % DEPTH;
   endfunction

   function automatic logic [DW-1:0] m_read(input int idx, input int ch);
      logic [CH*DW-1:0] w;
      if (idx >= m_filled() || ch >= CH) return '0;
      w = hist[hist.size() - m_filled() + idx];
      return w[ch*DW +: DW];
   endfunction

   task automatic m_reset();
      m_st = 0; m_mode = 0; m_post = 0; m_rem = 0; m_trig = -1;
      hist.delete();
   endtask

   task automatic m_update(input logic a, input logic sp, input int md, input int pc,
                           input logic tg, input logic v, input logic [CH*DW-1:0] d);
      if (a) begin
         m_st   = 1;
         hist.delete();
         m_mode = (md == 3) ? 0 : md;
         m_post = (pc > DEPTH - 1) ? DEPTH - 1 : pc;
         m_trig = -1;
         m_rem  = 0;
      end else if (m_st == 1) begin
         if (tg && m_mode != 2) begin
            m_trig = hist.size();
            if (m_mode == 1 && m_post != 0) begin
               m_st  = 2;
               m_rem = m_post;
            end else begin
               m_st = 3;
            end
         end
         if (v) hist.push_back(d);
         if (sp) m_st = 3;
      end else if (m_st == 2) begin
         if (v) begin
            hist.push_back(d);
            m_rem--;
            if (m_rem == 0) m_st = 3;
         end
         if (sp) m_st = 3;
      end
   endtask

   task automatic chk_status();
      chk("state", state, m_st);
      chk("filled", filled, m_filled());
      chk("trig_pos", trig_pos, m_trigpos());
      chk("done", done, (m_st == 3));
   endtask

   // One clock cycle: drive at the falling edge, score the state after the next rise.
   task automatic step(input logic a, input logic sp, input int md, input int pc,
                       input logic tg, input logic v, input logic [CH*DW-1:0] d,
                       input logic re, input int ri, input int rc);
      logic [1:0]    md_v;
      logic [AW:0]   pc_v;
      logic [AW-1:0] ri_v;
      logic [CW-1:0] rc_v;
      md_v = md[1:0]; pc_v = pc[AW:0]; ri_v = ri[AW-1:0]; rc_v = rc[CW-1:0];
      arm = a; stop = sp; mode = md_v; post_count = pc_v; trig = tg;
      smp_valid = v; smp_data = d; rd_en = re; rd_idx = ri_v; rd_ch = rc_v;
      if (re) exp_q.push_back(m_read(ri, rc));
      m_update(a, sp, md, pc, tg, v, d);
      @(posedge g_clk);
      @(negedge g_clk);
      chk_status();
   endtask

   function automatic logic [CH*DW-1:0] mk(input int k);
      logic [CH*DW-1:0] w;
      for (int c = 0; c < CH; c++) w[c*DW +: DW] = k + (c << 24);
      return w;
   endfunction

   task automatic do_arm(input int md, input int pc);
      step(1'b1, 1'b0, md, pc, 1'b0, 1'b0, '0, 1'b0, 0, 0);
   endtask

   task automatic smp(input int k, input logic tg, input logic sp);
      step(1'b0, sp, 0, 0, tg, 1'b1, mk(k), 1'b0, 0, 0);
   endtask

   task automatic rd(input int idx, input int ch);
      step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, '0, 1'b1, idx, ch);
   endtask

   task automatic pulse_reset();
      arm = 0; stop = 0; trig = 0; smp_valid = 0; rd_en = 0;
      #2 g_reset = 1'b1;
      #1;
      chk("rst_state", state, 0);
      chk("rst_filled", filled, 0);
      chk("rst_done", done, 0);
      chk("rst_trig_pos", trig_pos, 0);
      m_reset();
      exp_q.delete();
      last_rd = '0;
      @(negedge g_clk);
      #2 g_reset = 1'b0;
      @(negedge g_clk);
   endtask

   // Read monitor: every presented result must match the oldest outstanding request.
   always @(negedge g_clk) begin
      if (!g_reset) begin
         if (rd_valid) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL rd_unexpected: got valid data %0h with no request outstanding", rd_data);
            end else begin
               last_rd = exp_q.pop_front();
               chk("rd_data", rd_data, last_rd);
            end
         end else begin
            chk("rd_hold", rd_data, last_rd);
         end
      end
   end

   initial begin
      g_reset = 1'b1;
      arm = 0; stop = 0; mode = 0; post_count = 0; trig = 0;
      smp_valid = 0; smp_data = '0; rd_en = 0; rd_idx = 0; rd_ch = 0;
      m_reset();
      repeat (2) @(negedge g_clk);
      #2 g_reset = 1'b0;
      @(negedge g_clk);
      chk_status();
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);

      // Reset in the middle of a capture, then a fresh run counts from zero.
      do_arm(0, 0);
      for (int k = 0; k < 3; k++) smp(k, 1'b0, 1'b0);
      pulse_reset();
      chk_status();
      do_arm(0, 0);
      for (int k = 0; k < 2; k++) smp(k, 1'b0, 1'b0);
      chk("restart_filled", filled, 2);

      // Mode 0: trigger on the sixth sample.
      do_arm(0, 0);
      for (int k = 0; k < 5; k++) smp(k, 1'b0, 1'b0);
      smp(5, 1'b1, 1'b0);
      chk("m0_filled", filled, 6);
      chk("m0_trig_pos", trig_pos, 5);
      chk("m0_state", state, 3);
      for (int i = 0; i <= 6; i++) rd(i, 0);

      // Mode 1 with a three-sample post window after wrapping.
      do_arm(1, 3);
      for (int k = 0; k < 40; k++) smp(k, 1'b0, 1'b0);
      smp(40, 1'b1, 1'b0);
      for (int k = 41; k <= 43; k++) smp(k, 1'b0, 1'b0);
      chk("m1_filled", filled, 16);
      chk("m1_trig_pos", trig_pos, 12);
      rd(0, 0);
      rd(15, 0);

      // Mode 2: triggers ignored, stop is the only exit.
      do_arm(2, 0);
      for (int k = 0; k < 20; k++) smp(k, (k % 4) == 1, k == 19);
      chk("m2_filled", filled, 16);
      chk("m2_trig_pos", trig_pos, 0);
      rd(0, 0);

      // Same-cycle events.
      step(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, '0, 1'b0, 0, 0);
      chk("arm_stop_state", state, 1);
      for (int k = 0; k < 7; k++) smp(k, 1'b0, 1'b0);
      smp(7, 1'b1, 1'b1);
      chk("trig_stop_pos", trig_pos, 7);
      do_arm(1, 31);
      for (int k = 0; k < 4; k++) smp(k, 1'b0, 1'b0);
      smp(4, 1'b1, 1'b0);
      for (int k = 5; k < 19; k++) smp(k, 1'b0, 1'b0);
      chk("clip_still_trig", state, 2);
      smp(19, 1'b0, 1'b0);
      chk("clip_done", state, 3);

      // Channel selection with gaps in the sample stream.
      do_arm(2, 0);
      for (int i = 0; i < 10; i++)
         step(1'b0, 1'b0, 0, 0, 1'b0, (i % 3) != 1, {$urandom, $urandom, $urandom, $urandom},
              1'b0, 0, 0);
      step(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, '0, 1'b0, 0, 0);
      chk("gap_filled", filled, 7);
      for (int i = 0; i < 8; i++)
         for (int c = 0; c < CH; c++) rd(i, c);

      // Randomized runs with reads interleaved against capture.
      for (int r = 0; r < 12; r++) begin
         do_arm($urandom_range(0, 3), $urandom_range(0, 31));
         for (int c = 0; c < 40; c++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 3),
                 $urandom_range(0, 31), $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                 {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15), $urandom_range(0, 3));
         for (int c = 0; c < 16; c++) rd($urandom_range(0, 15), $urandom_range(0, 3));
      end

      step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, '0, 1'b0, 0, 0);
      step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, '0, 1'b0, 0, 0);
      chk("rd_drain", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
